uart_frame_loader: RTL and testbench

Byte-stream framer between the UART receiver and the program/data memory of the execution block. It consumes received bytes through the UART's level-held data-ready / clear handshake, hunts for a sync byte, and writes a length-prefixed, XOR-checksummed payload into memory. On a good frame it pulses `run`; it then returns a one-byte ACK or NAK through the UART transmitter.

---
 rtl/uart_frame_loader.sv | 200 ++++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// Framer between the UART receiver and execution-block memory: hunts for a sync byte,
// stores a length-prefixed XOR-checked payload, then answers with ACK or NAK.
module uart_frame_loader #(
    parameter int         ADDR_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ack,
    output logic [7:0]            tx_data,
    output logic                  tx_req,
    input  logic                  tx_busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  run,
    output logic                  frame_err,
    output logic                  in_frame
);

    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        RESP,
        WAIT_TX
    } state_t;

    state_t                  state_reg, state_next;
    logic                    ack_wait_reg, ack_wait_next;
    logic [7:0]              len_reg, len_next;
    logic [7:0]              chk_reg, chk_next;
    logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
    logic [TIMER_WIDTH-1:0]  timer_reg, timer_next;
    logic [7:0]              tx_data_reg, tx_data_next;
    logic                    tx_req_reg, tx_req_next;
    logic                    mem_we_reg, mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
    logic [7:0]              mem_wdata_reg, mem_wdata_next;
    logic                    run_reg, run_next;
    logic                    frame_err_reg, frame_err_next;
    logic                    in_frame_reg, in_frame_next;

    logic capturing;
    logic framing;
    logic capture;
    logic timeout;

    // Bytes are only taken while listening; RESP/WAIT_TX leave them with the UART.
    assign capturing = state_reg inside {HUNT, LEN, PAYLOAD, CHK};
    assign framing   = state_reg inside {LEN, PAYLOAD, CHK};
    assign capture   = capturing && rx_valid && !ack_wait_reg && !reset;
    assign timeout   = framing && !capture && (timer_reg == TIMER_LAST);

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        chk_next       = chk_reg;
        idx_next       = idx_reg;
        tx_data_next   = tx_data_reg;
        tx_req_next    = tx_req_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        run_next       = 1'b0;
        frame_err_next = 1'b0;

        // The data-ready line is level-held, so one capture per high period.
        if (capture) begin
            ack_wait_next = 1'b1;
        end else if (!rx_valid) begin
            ack_wait_next = 1'b0;
        end else begin
            ack_wait_next = ack_wait_reg;
        end

        timer_next = (capture || !framing) ? '0 : timer_reg + 1'b1;

        case (state_reg)
            HUNT: begin
                if (capture && rx_data == SYNC_BYTE) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (capture) begin
                    len_next   = rx_data;
                    chk_next   = rx_data;
                    idx_next   = '0;
                    state_next = (rx_data == 8'd0) ? CHK : PAYLOAD;
                end else if (timeout) begin
                    frame_err_next = 1'b1;
                    state_next     = HUNT;
                end
            end
            PAYLOAD: begin
                if (capture) begin
                    chk_next       = chk_reg ^ rx_data;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = idx_reg;
                    mem_wdata_next = rx_data;
                    idx_next       = idx_reg + 1'b1;
                    // len is at least 1 here, so len-1 cannot wrap.
                    if (idx_reg == ADDR_WIDTH'(len_reg - 8'd1)) begin
                        state_next = CHK;
                    end
                end else if (timeout) begin
                    frame_err_next = 1'b1;
                    state_next     = HUNT;
                end
            end
            CHK: begin
                if (capture) begin
                    if (rx_data == chk_reg) begin
                        run_next     = 1'b1;
                        tx_data_next = ACK_BYTE;
                    end else begin
                        frame_err_next = 1'b1;
                        tx_data_next   = NAK_BYTE;
                    end
                    state_next = RESP;
                end else if (timeout) begin
                    frame_err_next = 1'b1;
                    state_next     = HUNT;
                end
            end
            RESP: begin
                if (!tx_busy) begin
                    tx_req_next = 1'b1;
                    state_next  = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_busy) begin
                    tx_req_next = 1'b0;
                    state_next  = HUNT;
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase

        in_frame_next = state_next inside {LEN, PAYLOAD, CHK};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= HUNT;
            ack_wait_reg  <= 1'b0;
            len_reg       <= '0;
            chk_reg       <= '0;
            idx_reg       <= '0;
            timer_reg     <= '0;
            tx_data_reg   <= '0;
            tx_req_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            run_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
            in_frame_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ack_wait_reg  <= ack_wait_next;
            len_reg       <= len_next;
            chk_reg       <= chk_next;
            idx_reg       <= idx_next;
            timer_reg     <= timer_next;
            tx_data_reg   <= tx_data_next;
            tx_req_reg    <= tx_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            run_reg       <= run_next;
            frame_err_reg <= frame_err_next;
            in_frame_reg  <= in_frame_next;
        end
    end

    assign rx_ack    = capture;
    assign tx_data   = tx_data_reg;
    assign tx_req    = tx_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign run       = run_reg;
    assign frame_err = frame_err_reg;
    assign in_frame  = in_frame_reg;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: frame-level model feeds expectation queues that a
// single negedge compare process checks against memory writes, run/frame_err and responses.
module tb_uart_frame_loader;

    localparam int         ADDR_WIDTH = 8;
    localparam int         TIMEOUT    = 50;
    localparam logic [7:0] SYNC       = 8'hA5;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ack;
    logic [7:0]            tx_data;
    logic                  tx_req;
    logic                  tx_busy;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  run;
    logic                  frame_err;
    logic                  in_frame;

    logic hold_busy;
    logic auto_busy;
    assign tx_busy = hold_busy | auto_busy;

    uart_frame_loader #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(TIMEOUT),
        .ACK_BYTE(ACK),
        .NAK_BYTE(NAK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ack(rx_ack),
        .tx_data(tx_data),
        .tx_req(tx_req),
        .tx_busy(tx_busy),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .run(run),
        .frame_err(frame_err),
        .in_frame(in_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ack_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectations produced by the frame model.
    logic [15:0] exp_wr[$];
    int          exp_evt_kind[$];   // 1 = run, 2 = frame_err
    int          exp_evt_cyc[$];
    logic [7:0]  exp_tx[$];
    int          pending_kind = 0;
    int          pending_delay = 1;

    // Observation log for literal pins.
    int                    run_count = 0;
    int                    err_count = 0;
    int                    wr_count = 0;
    logic [7:0]            last_tx = 8'h00;
    logic [ADDR_WIDTH-1:0] last_wr_addr = '0;
    logic [7:0]            last_wr_data = 8'h00;
    int                    rise_cyc = 0;

    logic [7:0] frame_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] actual);
        n_checks++;
        n_errors++;
        $display("FAIL %s: observed %0h where nothing was expected (cycle %0d)", name, actual, cyc);
    endtask

    // Compare process.
    logic        prev_req = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_reset = 1'b1;
    logic [15:0] wr_e;
    int          ev_k;
    int          ev_c;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_we === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    flag("unexpected_write", {mem_addr, mem_wdata});
                end else begin
                    wr_e = exp_wr.pop_front();
                    check("wr_addr", mem_addr, wr_e[15:8]);
                    check("wr_data", mem_wdata, wr_e[7:0]);
                    check("wr_latency", cyc, ack_cyc + 1);
                end
                wr_count++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
            end
            if (run === 1'b1 && frame_err === 1'b1) begin
                flag("run_and_err", 32'h3);
            end else if (run === 1'b1 || frame_err === 1'b1) begin
                if (exp_evt_kind.size() == 0) begin
                    flag("unexpected_event", {run, frame_err});
                end else begin
                    ev_k = exp_evt_kind.pop_front();
                    ev_c = exp_evt_cyc.pop_front();
                    check("event_kind", run ? 1 : 2, ev_k);
                    check("event_cycle", cyc, ev_c);
                end
                if (run === 1'b1) run_count++;
                else err_count++;
            end
            if (exp_evt_cyc.size() > 0 && cyc > exp_evt_cyc[0]) begin
                ev_k = exp_evt_kind.pop_front();
                ev_c = exp_evt_cyc.pop_front();
                flag("missing_event", ev_k);
            end
            if (tx_req === 1'b1 && prev_req !== 1'b1) begin
                check("tx_req_gate", prev_busy, 0);
                if (exp_tx.size() == 0) flag("unexpected_tx", tx_data);
                else check("tx_data", tx_data, exp_tx.pop_front());
                last_tx = tx_data;
                rise_cyc = cyc;
            end
            if (tx_req === 1'b0 && prev_req === 1'b1 && prev_reset !== 1'b1) begin
                check("tx_req_hold", prev_busy, 1);
            end
            if (rx_ack === 1'b1 && prev_ack === 1'b1) begin
                flag("ack_pulse", 32'h1);
            end
        end
        prev_req   = tx_req;
        prev_busy  = tx_busy;
        prev_ack   = rx_ack;
        prev_reset = reset;
    end

    // UART transmitter stand-in: goes busy two cycles after a request.
    initial begin
        auto_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_req === 1'b1 && !auto_busy) begin
                repeat (2) @(posedge clk);
                #1 auto_busy = 1'b1;
                repeat (4) @(posedge clk);
                #1 auto_busy = 1'b0;
            end
        end
    end

    // One-cycle data-ready pulse; called and returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input logic expect_cap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        check("rx_ack_capture", rx_ack, expect_cap);
        if (rx_ack === 1'b1) begin
            ack_cyc = cyc;
            if (pending_kind != 0) begin
                exp_evt_kind.push_back(pending_kind);
                exp_evt_cyc.push_back(ack_cyc + pending_delay);
                pending_kind = 0;
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Frame model: locate the sync byte, read length, payload and XOR of length+payload.
    task automatic play_frame();
        int         pos;
        int         n;
        logic [7:0] x;
        logic       good;
        pos = 0;
        while (pos < frame_q.size() && frame_q[pos] != SYNC) pos++;
        n = int'(frame_q[pos+1]);
        x = frame_q[pos+1];
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({8'(i), frame_q[pos+2+i]});
            x = x ^ frame_q[pos+2+i];
        end
        good = (frame_q[pos+2+n] == x);
        exp_tx.push_back(good ? ACK : NAK);
        for (int k = 0; k < frame_q.size(); k++) begin
            if (k == pos + 2 + n) begin
                pending_kind  = good ? 1 : 2;
                pending_delay = 1;
            end
            send_byte(frame_q[k], 1'b1);
            if (k == pos) check("in_frame_after_sync", in_frame, 1);
        end
        check("in_frame_after_chk", in_frame, 0);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((exp_tx.size() != 0 || exp_evt_kind.size() != 0 || tx_req !== 1'b0 || tx_busy !== 1'b0) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, "_idle"}, t < 300, 1);
        check({tag, "_writes_drained"}, exp_wr.size(), 0);
        $display("frame %s: writes=%0d runs=%0d errs=%0d last_tx=%02h", tag, wr_count, run_count, err_count, last_tx);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ack"}, rx_ack, 0);
        check({tag, "_tx_req"}, tx_req, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_run"}, run, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_in_frame"}, in_frame, 0);
    endtask

    initial begin
        #400000;
        flag("watchdog", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int acks;
        int first_ack;
        int release_cyc;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        hold_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Good frame.
        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        play_frame();
        wait_idle("good");
        check("good_runs", run_count, 1);
        check("good_errs", err_count, 0);
        check("good_tx", last_tx, 8'h06);
        check("good_writes", wr_count, 3);
        check("good_last_wr", {last_wr_addr, last_wr_data}, 16'h0233);

        // Bad checksum.
        frame_q = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        play_frame();
        wait_idle("badchk");
        check("badchk_runs", run_count, 1);
        check("badchk_errs", err_count, 1);
        check("badchk_tx", last_tx, 8'h15);
        check("badchk_last_wr", {last_wr_addr, last_wr_data}, 16'h0155);

        // Hunt past noise, then a zero-length frame.
        frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        play_frame();
        wait_idle("zerolen");
        check("zerolen_runs", run_count, 2);
        check("zerolen_writes", wr_count, 5);
        check("zerolen_tx", last_tx, 8'h06);

        // Data-ready held high for 20 cycles: exactly one capture.
        acks = 0;
        first_ack = -1;
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_ack === 1'b1) begin
                acks++;
                if (first_ack < 0) first_ack = i;
                ack_cyc = cyc;
            end
            @(posedge clk); #1;
            if (i == 9) rx_data = 8'h01;
        end
        check("held_acks", acks, 1);
        check("held_first_ack", first_ack, 0);
        check("held_in_frame", in_frame, 1);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        exp_wr.push_back({8'h00, 8'h42});
        exp_tx.push_back(ACK);
        send_byte(8'h01, 1'b1);
        send_byte(8'h42, 1'b1);
        pending_kind  = 1;
        pending_delay = 1;
        send_byte(8'h43, 1'b1);
        wait_idle("held");
        check("held_runs", run_count, 3);

        // Silence mid-payload: timeout, no response.
        exp_wr.push_back({8'h00, 8'h11});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        pending_kind  = 2;
        pending_delay = TIMEOUT + 1;
        send_byte(8'h11, 1'b1);
        repeat (60) @(posedge clk);
        #1;
        check("timeout_in_frame", in_frame, 0);
        check("timeout_events_left", exp_evt_kind.size(), 0);
        check("timeout_errs", err_count, 2);
        check("timeout_no_tx", tx_req, 0);
        $display("frame timeout: writes=%0d runs=%0d errs=%0d", wr_count, run_count, err_count);
        frame_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        play_frame();
        wait_idle("after_timeout");
        check("after_timeout_runs", run_count, 4);
        check("after_timeout_last_wr", {last_wr_addr, last_wr_data}, 16'h007E);

        // Reset in the middle of a payload.
        exp_wr.push_back({8'h00, 8'h01});
        exp_wr.push_back({8'h01, 8'h02});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("midreset");
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (60) @(posedge clk);
        #1;
        check("midreset_writes", wr_count, 10);
        check("midreset_in_frame", in_frame, 0);
        $display("frame midreset: writes=%0d runs=%0d errs=%0d", wr_count, run_count, err_count);

        // Transmitter busy for 30 cycles after a good frame.
        hold_busy = 1'b1;
        frame_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        play_frame();
        acks = 0;
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_ack === 1'b1) acks++;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_ack", acks, 0);
        check("bp_no_req", tx_req, 0);
        check("bp_tx_pending", exp_tx.size(), 1);
        release_cyc = cyc;
        hold_busy = 1'b0;
        wait_idle("backpressure");
        check("bp_req_after_release", rise_cyc > release_cyc, 1);
        check("bp_runs", run_count, 5);
        check("bp_tx", last_tx, 8'h06);

        check("end_wr_queue", exp_wr.size(), 0);
        check("end_evt_queue", exp_evt_kind.size(), 0);
        check("end_tx_queue", exp_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
